// File: rtl/wb_stage_reg.sv
// MEM/WB pipeline latch with sub-word load extraction, write-back mux,
// one-shot register-file write, sticky halt and retired-instruction count.
module wb_stage_reg #(
  parameter int NB_DATA       = 32,
  parameter int NB_ADDR       = 7,
  parameter int NB_REG        = 5,
  parameter int NB_MEM_TO_REG = 2,
  parameter int NB_COUNT      = 32
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     enable_i,
  input  logic                     flush_i,
  input  logic                     valid_i,
  input  logic [NB_DATA-1:0]       mem_data_i,
  input  logic [NB_DATA-1:0]       alu_result_i,
  input  logic [NB_ADDR-1:0]       pc_i,
  input  logic [NB_DATA-1:0]       inm_ext_i,
  input  logic [NB_MEM_TO_REG-1:0] mem_to_reg_i,
  input  logic [1:0]               load_size_i,
  input  logic                     load_signed_i,
  input  logic [1:0]               byte_off_i,
  input  logic                     reg_write_i,
  input  logic [NB_REG-1:0]        rd_i,
  input  logic                     halt_i,
  output logic [NB_DATA-1:0]       wb_data_o,
  output logic [NB_REG-1:0]        wb_reg_o,
  output logic                     wb_write_o,
  output logic                     halt_o,
  output logic [NB_COUNT-1:0]      retired_o
);

  logic                     valid_q;
  logic                     fresh_q;
  logic [NB_DATA-1:0]       mem_data_q;
  logic [NB_DATA-1:0]       alu_q;
  logic [NB_ADDR-1:0]       pc_q;
  logic [NB_DATA-1:0]       inm_q;
  logic [NB_MEM_TO_REG-1:0] mux_q;
  logic [1:0]               size_q;
  logic                     sgn_q;
  logic [1:0]               off_q;
  logic                     regw_q;
  logic [NB_REG-1:0]        rd_q;
  logic                     halt_q;
  logic [NB_COUNT-1:0]      ret_q;

  logic capture;
  logic live;

  assign capture = enable_i & ~halt_q;
  assign live    = valid_i & ~flush_i;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_q    <= 1'b0;
      fresh_q    <= 1'b0;
      mem_data_q <= '0;
      alu_q      <= '0;
      pc_q       <= '0;
      inm_q      <= '0;
      mux_q      <= '0;
      size_q     <= '0;
      sgn_q      <= 1'b0;
      off_q      <= '0;
      regw_q     <= 1'b0;
      rd_q       <= '0;
      halt_q     <= 1'b0;
      ret_q      <= '0;
    end else begin
      // fresh_q drops on any non-capturing edge so a held slot writes once
      fresh_q <= capture;
      if (capture) begin
        valid_q    <= live;
        mem_data_q <= mem_data_i;
        alu_q      <= alu_result_i;
        pc_q       <= pc_i;
        inm_q      <= inm_ext_i;
        mux_q      <= mem_to_reg_i;
        size_q     <= load_size_i;
        sgn_q      <= load_signed_i;
        off_q      <= byte_off_i;
        regw_q     <= reg_write_i;
        rd_q       <= rd_i;
        if (live) begin
          ret_q <= ret_q + {{(NB_COUNT-1){1'b0}}, 1'b1};
          if (halt_i)
            halt_q <= 1'b1;
        end
      end
    end
  end

  logic [7:0]         lane_b;
  logic [15:0]        lane_h;
  logic [NB_DATA-1:0] load_val;

  assign lane_b = mem_data_q[{off_q, 3'b000} +: 8];
  assign lane_h = mem_data_q[{off_q[1], 4'b0000} +: 16];

  always_comb begin
    load_val = mem_data_q;
    unique case (size_q)
      2'b00:   load_val = {{(NB_DATA-8){sgn_q & lane_b[7]}}, lane_b};
      2'b01:   load_val = {{(NB_DATA-16){sgn_q & lane_h[15]}}, lane_h};
      default: load_val = mem_data_q;
    endcase
  end

  always_comb begin
    wb_data_o = load_val;
    unique case (mux_q)
      2'b00:   wb_data_o = load_val;
      2'b01:   wb_data_o = alu_q;
      2'b10:   wb_data_o = {{(NB_DATA-NB_ADDR){1'b0}}, pc_q};
      default: wb_data_o = inm_q;
    endcase
  end

  assign wb_reg_o   = rd_q;
  assign wb_write_o = valid_q & regw_q & (rd_q != '0) & fresh_q;
  assign halt_o     = halt_q;
  assign retired_o  = ret_q;

endmodule

// File: tb/tb_wb_stage_reg.sv
// Bench for wb_stage_reg: directed cases plus random traffic
// checked against a transaction-level reference model.
module tb_wb_stage_reg;

  localparam int NBC = 4;

  logic        clk = 1'b0;
  logic        reset_i, enable_i, flush_i, valid_i;
  logic [31:0] mem_data_i, alu_result_i, inm_ext_i;
  logic [6:0]  pc_i;
  logic [1:0]  mem_to_reg_i, load_size_i, byte_off_i;
  logic        load_signed_i, reg_write_i, halt_i;
  logic [4:0]  rd_i;
  logic [31:0] wb_data_o;
  logic [4:0]  wb_reg_o;
  logic        wb_write_o, halt_o;
  logic [NBC-1:0] retired_o;

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] e_data;
  logic [4:0]  e_reg;
  logic        e_write, e_halt;
  int          e_ret;

  wb_stage_reg #(.NB_COUNT(NBC)) dut (
    .clk_i(clk), .reset_i(reset_i), .enable_i(enable_i),
    .flush_i(flush_i), .valid_i(valid_i), .mem_data_i(mem_data_i),
    .alu_result_i(alu_result_i), .pc_i(pc_i), .inm_ext_i(inm_ext_i),
    .mem_to_reg_i(mem_to_reg_i), .load_size_i(load_size_i),
    .load_signed_i(load_signed_i), .byte_off_i(byte_off_i),
    .reg_write_i(reg_write_i), .rd_i(rd_i), .halt_i(halt_i),
    .wb_data_o(wb_data_o), .wb_reg_o(wb_reg_o),
    .wb_write_o(wb_write_o), .halt_o(halt_o), .retired_o(retired_o)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_data();
    logic [31:0] v;
    int sh;
    case (mem_to_reg_i)
      2'd1: return alu_result_i;
      2'd2: return {25'd0, pc_i};
      2'd3: return inm_ext_i;
      default: ;
    endcase
    if (load_size_i == 2'd0) begin
      sh = 8 * int'(byte_off_i);
      v = (mem_data_i >> sh) & 32'hFF;
      if (load_signed_i && v >= 32'h80) v = v - 32'h100;
    end else if (load_size_i == 2'd1) begin
      sh = byte_off_i[1] ? 16 : 0;
      v = (mem_data_i >> sh) & 32'hFFFF;
      if (load_signed_i && v >= 32'h8000) v = v - 32'h10000;
    end else begin
      v = mem_data_i;
    end
    return v;
  endfunction

  task automatic model();
    if (reset_i) begin
      e_data = 0; e_reg = 0; e_write = 0; e_halt = 0; e_ret = 0;
    end else if (enable_i && !e_halt) begin
      e_data  = ref_data();
      e_reg   = rd_i;
      e_write = valid_i && !flush_i && reg_write_i && rd_i != 0;
      if (valid_i && !flush_i) begin
        e_ret = (e_ret + 1) % (1 << NBC);
        if (halt_i) e_halt = 1;
      end
    end else begin
      e_write = 0;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model();
    #1;
    chk("wb_data", wb_data_o, e_data);
    chk("wb_reg", {27'd0, wb_reg_o}, {27'd0, e_reg});
    chk("wb_write", {31'd0, wb_write_o}, {31'd0, e_write});
    chk("halt", {31'd0, halt_o}, {31'd0, e_halt});
    chk("retired", {28'd0, retired_o}, e_ret);
    @(negedge clk);
  endtask

  task automatic idle();
    reset_i = 0; enable_i = 1; flush_i = 0; valid_i = 0;
    halt_i = 0; reg_write_i = 0; rd_i = 0;
  endtask

  task automatic op(logic [1:0] mux, logic [1:0] sz, logic sg,
                    logic [1:0] off, logic [31:0] mem, logic [4:0] rd);
    idle();
    valid_i = 1; reg_write_i = 1; mem_to_reg_i = mux;
    load_size_i = sz; load_signed_i = sg; byte_off_i = off;
    mem_data_i = mem; rd_i = rd;
  endtask

  task automatic rand_in();
    reset_i       = ($urandom % 60) == 0;
    enable_i      = ($urandom % 4) != 0;
    flush_i       = ($urandom % 6) == 0;
    valid_i       = ($urandom % 4) != 0;
    halt_i        = ($urandom % 30) == 0;
    reg_write_i   = ($urandom % 3) != 0;
    rd_i          = ($urandom % 5 == 0) ? 5'd0 : 5'($urandom);
    mem_data_i    = $urandom;
    alu_result_i  = $urandom;
    inm_ext_i     = $urandom;
    pc_i          = 7'($urandom);
    mem_to_reg_i  = 2'($urandom);
    load_size_i   = 2'($urandom);
    load_signed_i = 1'($urandom);
    byte_off_i    = 2'($urandom);
  endtask

  initial begin
    e_data = 0; e_reg = 0; e_write = 0; e_halt = 0; e_ret = 0;
    idle();
    mem_data_i = 0; alu_result_i = 0; inm_ext_i = 0; pc_i = 0;
    mem_to_reg_i = 0; load_size_i = 0; load_signed_i = 0; byte_off_i = 0;
    @(negedge clk);
    reset_i = 1; cycle();
    chk("reset_data", wb_data_o, 32'h0);

    op(2'b00, 2'b10, 0, 0, 32'h8000_00F0, 5'd3); cycle();
    chk("lw_data", wb_data_o, 32'h8000_00F0);
    chk("lw_ret", {28'd0, retired_o}, 32'd1);
    idle(); cycle();
    chk("lw_once", {31'd0, wb_write_o}, 32'd0);

    op(2'b00, 2'b00, 1, 1, 32'h1234_80FF, 5'd4); cycle();
    chk("lb_s", wb_data_o, 32'hFFFF_FF80);
    op(2'b00, 2'b00, 0, 1, 32'h1234_80FF, 5'd4); cycle();
    chk("lb_u", wb_data_o, 32'h0000_0080);
    op(2'b00, 2'b01, 1, 2, 32'h1234_80FF, 5'd4); cycle();
    chk("lh_2", wb_data_o, 32'h0000_1234);
    op(2'b00, 2'b01, 1, 3, 32'h1234_80FF, 5'd4); cycle();
    chk("lh_3", wb_data_o, 32'h0000_1234);

    op(2'b10, 2'b10, 0, 0, 0, 5'd31); pc_i = 7'h5A; cycle();
    chk("jal", wb_data_o, 32'h0000_005A);
    op(2'b01, 2'b10, 0, 0, 0, 5'd0); cycle();
    chk("r0_wr", {31'd0, wb_write_o}, 32'd0);

    op(2'b01, 2'b10, 0, 0, 0, 5'd7); alu_result_i = 32'hCAFE_0001; cycle();
    enable_i = 0; cycle(); cycle(); cycle();
    chk("hold_data", wb_data_o, 32'hCAFE_0001);
    op(2'b01, 2'b10, 0, 0, 0, 5'd8); flush_i = 1; cycle();

    op(2'b11, 2'b10, 0, 0, 0, 5'd9); inm_ext_i = 32'h1357_9000;
    halt_i = 1; cycle();
    chk("halt_set", {31'd0, halt_o}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      op(2'b01, 2'b10, 0, 0, 0, 5'd10); alu_result_i = $urandom; cycle();
    end
    idle(); reset_i = 1; enable_i = 0; cycle();

    for (int i = 0; i < 17; i++) begin
      op(2'b01, 2'b10, 0, 0, 0, 5'(i)); alu_result_i = i; cycle();
    end
    chk("wrap", {28'd0, retired_o}, 32'd1);
    op(2'b01, 2'b10, 0, 0, 0, 5'd2); halt_i = 1; flush_i = 1; cycle();
    chk("flush_halt", {31'd0, halt_o}, 32'd0);

    for (int i = 0; i < 3000; i++) begin
      rand_in(); cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
